// File: rtl/phys_reg_reclaimer.sv
// Commit-side reclaim queue feeding the physical-register free list, one free per cycle.
// Optional double-free filter enabled by defining RECLAIM_DBL_FREE_CHK_EN.
module phys_reg_reclaimer #(
  parameter int PHYS_REGS = 64,
  parameter int PHYS_W    = $clog2(PHYS_REGS),
  parameter int Q_DEPTH   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              commit0_valid,
  input  logic              commit0_has_dest,
  input  logic [PHYS_W-1:0] commit0_old_pd,
  input  logic              commit1_valid,
  input  logic              commit1_has_dest,
  input  logic [PHYS_W-1:0] commit1_old_pd,
  output logic              commit_ready,
  output logic              free_valid,
  output logic [PHYS_W-1:0] free_pd,
  input  logic              flush_valid,
  output logic              err_dbl_free
);

  localparam int PTR_W = $clog2(Q_DEPTH);
  localparam int CNT_W = $clog2(Q_DEPTH + 1);

  logic [PHYS_W-1:0] mem [Q_DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;
  logic              qual0, qual1, enq0, enq1, deq;
  logic [1:0]        enq_n;

  // Conservative: a same-cycle drain is not credited toward room for two.
  assign commit_ready = (CNT_W'(Q_DEPTH) - count) >= CNT_W'(2);
  assign qual0 = commit_ready & commit0_valid & commit0_has_dest & ~flush_valid;
  assign qual1 = commit_ready & commit1_valid & commit1_has_dest & ~flush_valid;

  assign free_valid = (count != '0) && !flush_valid && rst_n;
  assign free_pd    = free_valid ? mem[head] : '0;
  assign deq        = free_valid;
  assign enq_n      = {1'b0, enq0} + {1'b0, enq1};

`ifdef RECLAIM_DBL_FREE_CHK_EN
  logic [PHYS_REGS-1:0] pend, pend_next;
  logic                 dup0, dup1, err_q;

  // Slot 1 also loses to an accepted slot 0 carrying the same register.
  assign dup0 = pend[commit0_old_pd];
  assign dup1 = pend[commit1_old_pd] || (enq0 && (commit0_old_pd == commit1_old_pd));
  assign enq0 = qual0 & ~dup0;
  assign enq1 = qual1 & ~dup1;
  assign err_dbl_free = err_q;

  always_comb begin
    pend_next = pend;
    if (deq)  pend_next[mem[head]]     = 1'b0;
    if (enq0) pend_next[commit0_old_pd] = 1'b1;
    if (enq1) pend_next[commit1_old_pd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend  <= '0;
      err_q <= 1'b0;
    end else begin
      if ((qual0 && dup0) || (qual1 && dup1)) err_q <= 1'b1;
      pend <= flush_valid ? '0 : pend_next;
    end
  end
`else
  assign enq0 = qual0;
  assign enq1 = qual1;
  assign err_dbl_free = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (enq0) mem[tail] <= commit0_old_pd;
    if (enq1) mem[enq0 ? tail + PTR_W'(1) : tail] <= commit1_old_pd;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_valid) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (deq) head <= head + PTR_W'(1);
      tail  <= tail + PTR_W'(enq_n);
      count <= count + CNT_W'(enq_n) - CNT_W'(deq);
    end
  end

endmodule

// File: tb/tb_phys_reg_reclaimer.sv
// Bench for phys_reg_reclaimer: vector table, hand sequences, randomized run against a queue model.
module tb_phys_reg_reclaimer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       commit0_valid, commit0_has_dest, commit1_valid, commit1_has_dest;
  logic [5:0] commit0_old_pd, commit1_old_pd;
  logic       commit_ready, free_valid, flush_valid, err_dbl_free;
  logic [5:0] free_pd;

  int checks = 0;
  int failures = 0;

  phys_reg_reclaimer dut (
    .clk(clk), .rst_n(rst_n),
    .commit0_valid(commit0_valid), .commit0_has_dest(commit0_has_dest), .commit0_old_pd(commit0_old_pd),
    .commit1_valid(commit1_valid), .commit1_has_dest(commit1_has_dest), .commit1_old_pd(commit1_old_pd),
    .commit_ready(commit_ready), .free_valid(free_valid), .free_pd(free_pd),
    .flush_valid(flush_valid), .err_dbl_free(err_dbl_free)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst_n; bit v0; bit h0; int p0; bit v1; bit h1; int p1; bit fl;
    bit chk; bit efv; int epd; bit erdy;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic addv(input bit r, input bit v0, input bit h0, input int p0, input bit v1,
                      input bit h1, input int p1, input bit fl, input bit c, input bit efv,
                      input int epd, input bit erdy);
    vec_t v;
    v.rst_n = r; v.v0 = v0; v.h0 = h0; v.p0 = p0; v.v1 = v1; v.h1 = h1; v.p1 = p1;
    v.fl = fl; v.chk = c; v.efv = efv; v.epd = epd; v.erdy = erdy;
    vt.push_back(v);
  endtask

  task automatic drive(input bit r, input bit v0, input bit h0, input int p0, input bit v1,
                       input bit h1, input int p1, input bit fl);
    rst_n = r; commit0_valid = v0; commit0_has_dest = h0; commit0_old_pd = 6'(p0);
    commit1_valid = v1; commit1_has_dest = h1; commit1_old_pd = 6'(p1); flush_valid = fl;
  endtask

  task automatic idle();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Reference model state: pending reclaims in commit order, sticky error.
  int mq[$];
  bit merr;

  function automatic bit in_q(input int pd);
    foreach (mq[k]) if (mq[k] == pd) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    int sent[$];
    int got[$];
    int pdn;
    int run;
    bit sat;

    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // rst v0 h0 p0 v1 h1 p1 fl | chk efv epd rdy
    addv(0, 0,0,0,  0,0,0,  0, 0, 0,0,1);
    addv(1, 0,0,0,  0,0,0,  0, 1, 0,0,1);
    addv(1, 1,1,40, 0,0,0,  0, 1, 0,0,1);
    addv(1, 0,0,0,  0,0,0,  0, 1, 1,40,1);
    addv(1, 0,0,0,  0,0,0,  0, 1, 0,0,1);
    addv(1, 1,1,33, 1,1,45, 0, 1, 0,0,1);
    addv(1, 0,0,0,  0,0,0,  0, 1, 1,33,1);
    addv(1, 0,0,0,  0,0,0,  0, 1, 1,45,1);
    addv(1, 0,0,0,  0,0,0,  0, 1, 0,0,1);
    addv(1, 1,0,7,  1,1,50, 0, 1, 0,0,1);
    addv(1, 0,0,0,  0,0,0,  0, 1, 1,50,1);
    addv(1, 0,0,0,  0,0,0,  0, 1, 0,0,1);
    addv(1, 1,1,10, 1,1,11, 0, 1, 0,0,1);
    addv(1, 1,1,12, 1,1,13, 0, 1, 1,10,1);
    addv(1, 1,1,14, 1,1,15, 0, 1, 1,11,1);
    addv(1, 1,1,60, 0,0,0,  1, 1, 0,0,1);
    addv(1, 0,0,0,  0,0,0,  0, 1, 0,0,1);
    addv(1, 0,0,0,  0,0,0,  0, 1, 0,0,1);
    addv(1, 1,1,20, 1,1,21, 0, 1, 0,0,1);
    addv(0, 1,1,22, 0,0,0,  0, 1, 0,0,1);
    addv(1, 0,0,0,  0,0,0,  0, 1, 0,0,1);

    foreach (vt[i]) begin
      next_cycle();
      drive(vt[i].rst_n, vt[i].v0, vt[i].h0, vt[i].p0, vt[i].v1, vt[i].h1, vt[i].p1, vt[i].fl);
      @(negedge clk);
      if (vt[i].chk) begin
        chk($sformatf("vec%0d_free_valid", i), int'(free_valid), int'(vt[i].efv));
        chk($sformatf("vec%0d_free_pd", i), int'(free_pd), vt[i].epd);
        chk($sformatf("vec%0d_commit_ready", i), int'(commit_ready), int'(vt[i].erdy));
      end
    end

    // Saturation: keep committing pairs whenever ready, then drain.
    pdn = 0; sat = 1'b0; run = 0;
    for (int c = 0; c < 30 && !sat; c++) begin
      next_cycle();
      if (commit_ready) begin
        drive(1, 1, 1, pdn, 1, 1, pdn + 1, 0);
        sent.push_back(pdn); sent.push_back(pdn + 1);
        pdn += 2;
      end else begin
        sat = 1'b1;
        idle();
      end
      @(negedge clk);
      if (free_valid) got.push_back(int'(free_pd));
      if (sat && free_valid) run++;
    end
    chk("sat_reached", int'(sat), 1);
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      idle();
      @(negedge clk);
      if (free_valid) begin
        got.push_back(int'(free_pd));
        run++;
      end
    end
    chk("sat_drain_frees", run, 7);
    chk("sat_total_frees", got.size(), sent.size());
    for (int k = 0; k < sent.size() && k < got.size(); k++)
      chk($sformatf("sat_order%0d", k), got[k], sent[k]);
    chk("sat_ready_after", int'(commit_ready), 1);

`ifdef RECLAIM_DBL_FREE_CHK_EN
    next_cycle(); drive(0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle(); drive(1, 1, 1, 37, 0, 0, 0, 0);
    @(negedge clk); chk("dbl_err_initial", int'(err_dbl_free), 0);
    next_cycle(); drive(1, 1, 1, 37, 0, 0, 0, 0);
    @(negedge clk); chk("dbl_free_pd37", int'(free_pd), 37);
    next_cycle(); idle();
    @(negedge clk);
    chk("dbl_no_second_free", int'(free_valid), 0);
    chk("dbl_err_set", int'(err_dbl_free), 1);
    next_cycle(); drive(1, 0, 0, 0, 0, 0, 0, 1);
    next_cycle(); idle();
    @(negedge clk); chk("dbl_err_after_flush", int'(err_dbl_free), 1);
    next_cycle(); drive(1, 1, 1, 9, 1, 1, 9, 0);
    next_cycle(); idle();
    @(negedge clk); chk("dbl_pair_free_pd", int'(free_pd), 9);
    next_cycle(); idle();
    @(negedge clk); chk("dbl_pair_single", int'(free_valid), 0);
`endif

    // Randomized run against the queue model.
    for (int i = 0; i < 600; i++) begin
      bit r, v0, h0, v1, h1, fl, busy, rdy, efv, q0, q1, a0, a1;
      int p0, p1, epd, pmax;
      next_cycle();
      busy = ((i / 40) % 2) == 0;
`ifdef RECLAIM_DBL_FREE_CHK_EN
      pmax = 15;
`else
      pmax = 63;
`endif
      r  = (i == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
      fl = ($urandom_range(0, 29) == 0);
      v0 = busy ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      v1 = busy ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      h0 = ($urandom_range(0, 4) != 0);
      h1 = ($urandom_range(0, 4) != 0);
      p0 = int'($urandom_range(0, pmax));
      p1 = int'($urandom_range(0, pmax));
      drive(r, v0, h0, p0, v1, h1, p1, fl);
      @(negedge clk);
      rdy = (8 - mq.size()) >= 2;
      efv = (mq.size() != 0) && !fl && r;
      epd = efv ? mq[0] : 0;
      if (i != 0) begin
        chk($sformatf("rnd%0d_commit_ready", i), int'(commit_ready), int'(rdy));
        chk($sformatf("rnd%0d_free_valid", i), int'(free_valid), int'(efv));
        chk($sformatf("rnd%0d_free_pd", i), int'(free_pd), epd);
        chk($sformatf("rnd%0d_err", i), int'(err_dbl_free), int'(merr));
      end
      if (!r) begin
        mq.delete(); merr = 1'b0;
      end else if (fl) begin
        mq.delete();
      end else begin
        q0 = rdy && v0 && h0;
        q1 = rdy && v1 && h1;
        a0 = q0; a1 = q1;
`ifdef RECLAIM_DBL_FREE_CHK_EN
        if (q0 && in_q(p0)) a0 = 1'b0;
        if (q1 && (in_q(p1) || (a0 && p0 == p1))) a1 = 1'b0;
        if ((q0 && !a0) || (q1 && !a1)) merr = 1'b1;
`endif
        if (efv) void'(mq.pop_front());
        if (a0) mq.push_back(p0);
        if (a1) mq.push_back(p1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/phys_reg_reclaimer.md
Name: phys_reg_reclaimer

Overview:
- Commit-side producer for the physical-register free list's free port (`free_valid`/`free_pd`).
- Accepts up to two retiring instructions per cycle from the ROB commit stage and captures each stale mapping (`old_pd`) in a small in-order queue.
- Drains one entry per cycle into the free list, which has no back-pressure on its free port.
- Discards all pending reclaims on pipeline flush, because the free list re-initialises itself on flush.

Parameters:
- `PHYS_REGS`, 64, number of physical registers.
- `PHYS_W`, `$clog2(PHYS_REGS)`, physical register index width.
- `Q_DEPTH`, 8, reclaim queue entries; power of two, at least 4.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `commit0_valid` input 1: slot 0 retiring (older instruction).
- `commit0_has_dest` input 1: slot 0 wrote a register; `old_pd` is meaningful.
- `commit0_old_pd` input `PHYS_W`: stale physical register for slot 0.
- `commit1_valid` input 1: slot 1 retiring (younger instruction).
- `commit1_has_dest` input 1: slot 1 wrote a register.
- `commit1_old_pd` input `PHYS_W`: stale physical register for slot 1.
- `commit_ready` output 1: queue can absorb two entries this cycle.
- `free_valid` output 1: to free list `free_valid`.
- `free_pd` output `PHYS_W`: to free list `free_pd`.
- `flush_valid` input 1: pipeline flush, same signal the free list sees.
- `err_dbl_free` output 1: sticky double-free error (optional feature only).

Behaviour:
- **Storage.**
  - Circular buffer `mem[Q_DEPTH]` with `head`/`tail` pointers of width `$clog2(Q_DEPTH)` that wrap naturally.
  - Occupancy `count` of width `$clog2(Q_DEPTH+1)`.
- **Reset (`rst_n=0` at posedge).**
  - `head`, `tail`, `count` all set to 0.
  - Resulting outputs: `free_valid=0`, `free_pd=0`, `commit_ready=1`, `err_dbl_free=0`.
  - Reset mid-operation discards all pending entries; no free is emitted in the reset cycle.
- **commit_ready.**
  - Combinational: `(Q_DEPTH - count) >= 2`.
  - Does not credit a same-cycle pop (conservative).
- **Enqueue.**
  - A slot enqueues only when `commit_ready=1`, `valid=1`, `has_dest=1` and `flush_valid=0`.
  - If `commit_ready=0`, both slots are ignored; upstream holds its commit.
  - Slot 1 valid with slot 0 invalid is legal; the bench need not generate it, but RTL handles it.
- **Enqueue ordering.**
  - Slot 0 is written at `tail`, slot 1 at `tail+1`, when both qualify.
  - If only one slot qualifies, it is written at `tail`.
  - `tail` advances by the number of qualifying slots (0, 1 or 2).
- **Drain.**
  - `free_valid = (count != 0) && !flush_valid`.
  - `free_pd = mem[head]` when `free_valid`, else 0.
  - Every cycle `free_valid=1`, `head` increments by 1; the free list always accepts.
- **Latency.** An entry enqueued at edge N is presented on `free_valid` in cycle N+1 at the earliest. There is no same-cycle bypass.
- **Count update.** `count_next = count + enq_n - deq`, where `enq_n` is 0..2 and `deq` is 0..1. Simultaneous enqueue and dequeue are exact, and `count` never exceeds `Q_DEPTH`.
- **Ordering.** Frees are emitted strictly in commit order (slot 0 before slot 1, older cycle first).
- **Flush (`flush_valid=1` at posedge).**
  - `head`, `tail`, `count` are set to 0.
  - Same-cycle commit inputs are ignored and `free_valid` is forced to 0 that cycle.
  - Flush takes priority over enqueue and dequeue; reset takes priority over flush.
- **Full/empty boundaries.**
  - `count = Q_DEPTH-1`: `commit_ready=0` even though one slot remains.
  - `count = 0`: `free_valid=0`, `free_pd=0`.
- **Commit order.** The block has no state machine beyond the queue.

Optional Feature:
- Macro: `RECLAIM_DBL_FREE_CHK_EN`.
- **Defined:**
  - Maintains a `PHYS_REGS`-bit pending bitmap: set on enqueue, cleared on drain, cleared entirely on flush and reset.
  - A qualifying slot whose `old_pd` bit is already set is dropped (not enqueued) and sets `err_dbl_free`.
  - The same applies when slot 0 and slot 1 carry an equal `old_pd` in one cycle: slot 1 is dropped.
  - `err_dbl_free` is sticky until reset; flush does not clear it.
- **Undefined:** no bitmap is built, `err_dbl_free` is tied 0, and duplicates are enqueued normally.

Test Plan:
- Reset, then slot 0 only {valid=1, has_dest=1, old_pd=40} -> next cycle `free_valid=1`, `free_pd=40`; following cycle `free_valid=0`.
- Both slots valid, `old_pd` 33 and 45, same cycle -> `free_pd=33` in cycle N+1, `free_pd=45` in cycle N+2, `count` returns to 0.
- Slot 0 `has_dest=0`, slot 1 {has_dest=1, old_pd=50} -> only 50 is freed, one cycle later.
- Hold both slots valid every cycle with distinct pds -> `count` saturates at 7 with `commit_ready=0`. Drop inputs -> exactly 7 frees emitted in order, 1 per cycle, with `tail` wrapping past 7.
- Queue holding 4 entries, assert `flush_valid` with a valid commit {old_pd=60} -> `free_valid=0` that cycle, no later free of 60 or of the 4 old entries, `commit_ready=1`.
- With `RECLAIM_DBL_FREE_CHK_EN`: enqueue pd 37, then pd 37 again before it drains -> a single free of 37, `err_dbl_free=1` and still 1 after a flush.
